// File: rtl/count_seq_pkg.sv
// count_seq_pkg -- shared definitions for the count sequencer.
//   state_t   : two-state controller encoding (IDLE, RUN)
//   DEF_WIDTH : default counter width in bits
//   DEF_PRE_W : default prescaler divide-field width
package count_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 4;

endpackage

// File: rtl/count_seq_core.sv
// count_seq_core -- loadable down-counter with reload and zero detect.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (count and stored reload value -> 0)
//   load     : capture load_val into both the counter and the reload register
//   load_val : value to load
//   step     : one counting tick; decrements, or reloads/holds when at zero
//   reload   : 1 = on a tick at zero, restore the stored value; 0 = hold at zero
//   count    : current counter value (registered)
//   zero     : count == 0 (combinational from the register)
module count_seq_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_val_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg      <= '0;
      reload_val_reg <= '0;
    end else if (load) begin
      count_reg      <= load_val;
      reload_val_reg <= load_val;
    end else if (step) begin
      if (count_reg != '0)
        count_reg <= count_reg - 1'b1;
      else if (reload)
        count_reg <= reload_val_reg;
      // otherwise a one-shot run parks at zero
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer -- start/stop controlled down-counter, one-shot or auto-reload.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : load and run request, honoured only in IDLE
//   stop     : abort request, honoured only in RUN (wins over a terminal tick)
//   mode     : 0 = one-shot, 1 = auto-reload; captured on accepted start
//   load_val : initial/reload count; captured on accepted start
//   presc    : (COUNT_SEQ_PRESCALE_EN only) tick every presc+1 cycles in RUN
//   count    : current count (registered)
//   busy     : high while in RUN (registered)
//   done     : one-cycle pulse after the terminal tick (registered)
// Build option: define COUNT_SEQ_PRESCALE_EN to add the presc input and the
// cycle prescaler; without it every RUN cycle is a tick.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRE_W-1:0] presc,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t state_reg;
  logic   busy_reg;
  logic   done_reg;
  logic   mode_reg;
  logic   tick;
  logic   zero;
  logic   load;
  logic   step;

  assign load = (state_reg == IDLE) && start;
  // stop has priority: an aborted cycle never advances the counter
  assign step = (state_reg == RUN) && !stop && tick;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRE_W-1:0] presc_reg;
  logic [PRE_W-1:0] presc_cnt_reg;

  // tick on the last cycle of each presc+1 cycle window
  assign tick = (presc_cnt_reg == presc_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
    end else if (load) begin
      presc_reg     <= presc;
      presc_cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      if (stop || tick)
        presc_cnt_reg <= '0;
      else
        presc_cnt_reg <= presc_cnt_reg + 1'b1;
    end
  end
`else
  // No prescaler: every RUN cycle counts. PRE_W only matters for the
  // prescaled build, so both branches degenerate to the same tick.
  if (PRE_W > 0) begin : g_tick_every_cycle
    assign tick = 1'b1;
  end else begin : g_tick_every_cycle_zw
    assign tick = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      mode_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            mode_reg  <= mode;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (tick && zero) begin
            done_reg <= 1'b1;
            if (!mode_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  count_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .step    (step),
    .reload  (mode_reg),
    .count   (count),
    .zero    (zero)
  );

  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer -- directed bench for count_sequencer with a queue-based
// reference model (each run is expanded into the list of count values it must
// show) compared on every cycle, plus literal expectations per scenario.
// Define COUNT_SEQ_PRESCALE_EN to also exercise the prescaler.
module tb_count_sequencer;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] load_val;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRE_W-1:0] presc;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  count_sequencer #(
    .WIDTH(WIDTH),
    .PRE_W(PRE_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .load_val(load_val),
`ifdef COUNT_SEQ_PRESCALE_EN
    .presc   (presc),
`endif
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run of value L with tick period P+1 displays L, L-1, ..., 0, each value
  // for P+1 cycles; the terminal tick happens when that list is exhausted.
  int q[$];
  bit m_run;
  bit m_mode;
  int m_L;
  int m_P;
  int e_count;
  bit e_busy;
  bit e_done;

  task automatic fill_run();
    q.delete();
    for (int v = m_L; v >= 0; v--)
      for (int r = 0; r <= m_P; r++)
        q.push_back(v);
  endtask

  initial begin
    m_run = 0; m_mode = 0; m_L = 0; m_P = 0;
    e_count = 0; e_busy = 0; e_done = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_run = 0; m_mode = 0;
        e_count = 0; e_busy = 0; e_done = 0;
      end else if (!m_run) begin
        e_done = 0;
        if (start) begin
          m_run  = 1;
          m_L    = int'(load_val);
          m_mode = mode;
`ifdef COUNT_SEQ_PRESCALE_EN
          m_P    = int'(presc);
`else
          m_P    = 0;
`endif
          fill_run();
          e_count = q[0];
          e_busy  = 1;
        end
      end else if (stop) begin
        m_run  = 0;
        e_busy = 0;
        e_done = 0;
        q.delete();
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          e_done = 1;
          if (m_mode) begin
            fill_run();
            e_count = q[0];
          end else begin
            m_run   = 0;
            e_busy  = 0;
            e_count = 0;
          end
        end else begin
          e_done  = 0;
          e_count = q[0];
        end
      end
      @(negedge clk);
      check("model_count", int'(count), e_count);
      check("model_busy",  int'(busy),  int'(e_busy));
      check("model_done",  int'(done),  int'(e_done));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int c, input int b, input int d);
    check({name, "_count"}, int'(count), c);
    check({name, "_busy"},  int'(busy),  b);
    check({name, "_done"},  int'(done),  d);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; load_val = '0;
`ifdef COUNT_SEQ_PRESCALE_EN
    presc = '0;
`endif
    cyc(); cyc();
    lit("reset", 0, 0, 0);
    rst_n = 1'b1;
    cyc();

    // one-shot L=3; mid-run start/load_val/mode changes must be ignored
    start = 1'b1; load_val = 4'd3; mode = 1'b0;
    cyc(); lit("os_t1", 3, 1, 0); start = 1'b0;
    cyc(); lit("os_t2", 2, 1, 0); start = 1'b1; load_val = 4'd9; mode = 1'b1;
    cyc(); lit("os_t3", 1, 1, 0); start = 1'b0;
    cyc(); lit("os_t4", 0, 1, 0);
    cyc(); lit("os_t5", 0, 0, 1);
    stop = 1'b1;
    cyc(); lit("os_t6", 0, 0, 0); stop = 1'b0;
    cyc(); lit("os_t7", 0, 0, 0);
    $display("txn one-shot L=3: count=%0d busy=%0d done=%0d", count, busy, done);

    // auto-reload L=2 for 12 cycles, then stop on a terminal tick
    start = 1'b1; load_val = 4'd2; mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      lit("ar", 2 - (k % 3), 1, (k > 0 && (k % 3) == 0) ? 1 : 0);
      start = 1'b0;
    end
    stop = 1'b1;
    cyc(); lit("ar_stop", 0, 0, 0); stop = 1'b0;
    $display("txn auto-reload L=2: count=%0d busy=%0d done=%0d", count, busy, done);

    // L=5, stop when count reaches 3
    start = 1'b1; load_val = 4'd5; mode = 1'b0;
    cyc(); lit("ab_t1", 5, 1, 0); start = 1'b0;
    cyc(); lit("ab_t2", 4, 1, 0);
    cyc(); lit("ab_t3", 3, 1, 0); stop = 1'b1;
    cyc(); lit("ab_t4", 3, 0, 0); stop = 1'b0;
    cyc(); lit("ab_t5", 3, 0, 0);
    $display("txn abort L=5: count=%0d busy=%0d done=%0d", count, busy, done);

    // L=0 one-shot: done straight after RUN entry
    start = 1'b1; load_val = 4'd0; mode = 1'b0;
    cyc(); lit("z_t1", 0, 1, 0); start = 1'b0;
    cyc(); lit("z_t2", 0, 0, 1);
    cyc(); lit("z_t3", 0, 0, 0);
    $display("txn zero-load: count=%0d busy=%0d done=%0d", count, busy, done);

    // start and stop together in RUN: stop wins
    start = 1'b1; load_val = 4'd4; mode = 1'b0;
    cyc(); lit("ss_t1", 4, 1, 0); stop = 1'b1;
    cyc(); lit("ss_t2", 4, 0, 0); start = 1'b0; stop = 1'b0;
    cyc(); lit("ss_t3", 4, 0, 0);
    $display("txn start+stop: count=%0d busy=%0d done=%0d", count, busy, done);

    // stop on the terminal tick suppresses done
    start = 1'b1; load_val = 4'd1; mode = 1'b0;
    cyc(); lit("st_t1", 1, 1, 0); start = 1'b0;
    cyc(); lit("st_t2", 0, 1, 0); stop = 1'b1;
    cyc(); lit("st_t3", 0, 0, 0); stop = 1'b0;
    cyc(); lit("st_t4", 0, 0, 0);
    $display("txn stop-on-terminal: count=%0d busy=%0d done=%0d", count, busy, done);

    // reset mid-run at count=2, with start held high
    start = 1'b1; load_val = 4'd4; mode = 1'b1;
    cyc(); lit("rs_t1", 4, 1, 0);
    cyc(); lit("rs_t2", 3, 1, 0);
    cyc(); lit("rs_t3", 2, 1, 0); rst_n = 1'b0;
    cyc(); lit("rs_t4", 0, 0, 0); rst_n = 1'b1; start = 1'b0;
    cyc(); lit("rs_t5", 0, 0, 0);
    $display("txn reset mid-run: count=%0d busy=%0d done=%0d", count, busy, done);

`ifdef COUNT_SEQ_PRESCALE_EN
    // presc=2, L=1 one-shot: value changes every 3 cycles, done after 6
    start = 1'b1; load_val = 4'd1; mode = 1'b0; presc = 4'd2;
    for (int k = 0; k < 6; k++) begin
      cyc();
      lit("ps", (k < 3) ? 1 : 0, 1, 0);
      start = 1'b0;
    end
    cyc(); lit("ps_done", 0, 0, 1);
    cyc(); lit("ps_after", 0, 0, 0);
    $display("txn prescale presc=2 L=1: count=%0d busy=%0d done=%0d", count, busy, done);

    // prescaled auto-reload, aborted mid-window, restarted: window restarts
    start = 1'b1; load_val = 4'd2; mode = 1'b1; presc = 4'd1;
    cyc(); start = 1'b0;
    cyc(); stop = 1'b1;
    cyc(); stop = 1'b0; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      start = 1'b0;
    end
    stop = 1'b1;
    cyc(); stop = 1'b0;
    cyc();
    $display("txn prescale reload/abort: count=%0d busy=%0d done=%0d", count, busy, done);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL provide parameter: WIDTH, 4, counter width in bits.
REQ-002 The block SHALL provide parameter: PRE_W, 4, prescaler divide-field width (used only with COUNT_SEQ_PRESCALE_EN).
REQ-003 The block SHALL provide port: clk  input  1  clock; all state updates on rising edge.
REQ-004 The block SHALL provide port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL provide port: start  input  1  request to load and run; sampled only in IDLE.
REQ-006 The block SHALL provide port: stop  input  1  abort request; sampled only in RUN.
REQ-007 The block SHALL provide port: mode  input  1  0 = one-shot, 1 = auto-reload; latched on accepted start.
REQ-008 The block SHALL provide port: load_val  input  WIDTH  initial/reload count; latched on accepted start.
REQ-009 The block SHALL provide port: count  output  WIDTH  current counter value, registered.
REQ-010 The block SHALL provide port: busy  output  1  high while in RUN, registered.
REQ-011 The block SHALL provide port: done  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 In IDLE, start=1 at edge N SHALL set count=load_val, latch load_val and mode, and enter RUN after edge N.
REQ-014 In RUN, on each tick with count!=0, count SHALL decrement by 1; no wrap below 0.
REQ-015 In RUN, on a tick with count==0, done SHALL be 1 for exactly the following cycle.
REQ-016 On that terminal tick with latched mode=1, count SHALL reload the latched value and remain in RUN; period = L+1 ticks.
REQ-017 On that terminal tick with latched mode=0, the FSM SHALL return to IDLE with count held at 0.
REQ-018 load_val=0 SHALL produce done on the first tick in RUN.
REQ-019 stop=1 in RUN SHALL return to IDLE at the next edge, hold count, and suppress done, even on a terminal tick.
REQ-020 start in RUN and stop in IDLE SHALL be ignored; changes to load_val/mode in RUN SHALL have no effect.
REQ-021 Without prescaler, every clock cycle in RUN SHALL be a tick.

Reset
REQ-022 rst_n=0 at an edge SHALL force IDLE, count=0, busy=0, done=0, latched value=0, mode=0, prescaler=0, overriding all inputs including mid-RUN.

Configuration
REQ-023 With COUNT_SEQ_PRESCALE_EN defined, the block SHALL add input presc [PRE_W-1:0] latched on accepted start, producing a tick every presc+1 cycles in RUN; the prescaler SHALL clear on start, stop and reset.
REQ-024 With COUNT_SEQ_PRESCALE_EN undefined, port presc and prescaler logic SHALL be absent and REQ-021 applies.

Structure
REQ-025 A shared package count_seq_pkg SHALL hold the state enum (IDLE, RUN) and default WIDTH/PRE_W constants.
REQ-026 The down-counter with load/reload/zero-detect SHALL be a sub-module count_seq_core; the FSM and prescaler SHALL live in count_sequencer.

Verification
REQ-027 The bench SHALL cover: reset, start=1, load_val=3, mode=0 -> count 3,2,1,0 on successive cycles, done high one cycle after count reaches 0, busy low thereafter, count stays 0.
REQ-028 The bench SHALL cover: load_val=2, mode=1, run 12 cycles -> done every 3 cycles, count sequence 2,1,0,2,1,0..., busy stays 1.
REQ-029 The bench SHALL cover: load_val=5, stop asserted when count=3 -> next cycle IDLE, count=3, busy=0, no done.
REQ-030 The bench SHALL cover: load_val=0, mode=0 -> done one cycle after RUN entry; start and stop together in RUN -> stop wins.
REQ-031 The bench SHALL cover: rst_n=0 mid-RUN with count=2 -> next cycle count=0, busy=0, done=0.
REQ-032 The bench SHALL cover, with COUNT_SEQ_PRESCALE_EN: presc=2, load_val=1, mode=0 -> count changes every 3 cycles, done after 6 cycles in RUN.
